// File: rtl/cordic_floatingpoint_addsub_normalize.sv
// Normalizing back end of the floating-point add/sub path: converts a signed
// mantissa sum into sign/exponent/fraction using one right shift or iterative left shifts.
module cordic_floatingpoint_addsub_normalize #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MANT_W+1:0]   sum_in,
    input  logic [EXP_W-1:0]    exp_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                sign_out,
    output logic [EXP_W-1:0]    exp_out,
    output logic [MANT_W-2:0]   frac_out,
    output logic                zero_out,
    output logic                overflow_out,
    output logic                underflow_out
);
    localparam int SW = MANT_W + 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; out_valid and all result fields hold steady until out_ready.
    logic [1:0]       state;
    logic [SW-1:0]    mag;
    logic [EXP_W-1:0] exp_reg;
    logic             sign_reg;
    logic             zero_reg;
    logic             ovf_reg;
    logic             unf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mag      <= '0;
            exp_reg  <= '0;
            sign_reg <= 1'b0;
            zero_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            unf_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_reg <= sum_in[SW-1];
                        mag      <= sum_in[SW-1] ? (~sum_in + SW'(1)) : sum_in;
                        exp_reg  <= exp_in;
                        zero_reg <= 1'b0;
                        ovf_reg  <= 1'b0;
                        unf_reg  <= 1'b0;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (mag == '0) begin
                        zero_reg <= 1'b1;
                        sign_reg <= 1'b0;
                        exp_reg  <= '0;
                        state    <= DONE;
                    end else if (mag[MANT_W]) begin
                        // Carry out of the hidden bit; saturate to infinity when the exponent is already maximal.
                        if (&exp_reg) begin
                            ovf_reg <= 1'b1;
                            mag     <= '0;
                        end else begin
                            mag     <= mag >> 1;
                            exp_reg <= exp_reg + EXP_W'(1);
                        end
                        state <= DONE;
                    end else if (mag[MANT_W-1]) begin
                        state <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (exp_reg <= EXP_W'(1)) begin
                        unf_reg  <= 1'b1;
                        sign_reg <= 1'b0;
                        exp_reg  <= '0;
                        mag      <= '0;
                        state    <= DONE;
                    end else begin
                        mag     <= mag << 1;
                        exp_reg <= exp_reg - EXP_W'(1);
                        if (mag[MANT_W-2]) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        zero_reg <= 1'b0;
                        ovf_reg  <= 1'b0;
                        unf_reg  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state == IDLE);
    assign out_valid     = (state == DONE);
    assign sign_out      = sign_reg;
    assign exp_out       = exp_reg;
    assign frac_out      = mag[MANT_W-2:0];
    assign zero_out      = zero_reg;
    assign overflow_out  = ovf_reg;
    assign underflow_out = unf_reg;
endmodule

// File: doc/cordic_floatingpoint_addsub_normalize.md
Name: cordic_floatingpoint_addsub_normalize

Overview:
- Back end of the floating-point add/sub path. It takes the signed two's-complement mantissa sum produced after conditional negation and addition, and returns a normalized sign/exponent/fraction result.
- It recovers sign and magnitude by negating the sum when it is negative. It then normalizes by one right shift or by iterative left shifts.
- Iterative shifting keeps area minimal. Valid/ready handshakes are used on both sides.

Parameters:
- MANT_W, 24, mantissa width including the hidden bit. The hidden bit sits at position MANT_W-1.
- EXP_W, 8, biased exponent width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  sum_in/exp_in are valid.
- in_ready  output  1  block can accept a new operand. Equals (state==IDLE).
- sum_in  input  MANT_W+2  signed two's-complement mantissa sum. The hidden-bit weight is bit MANT_W-1.
- exp_in  input  EXP_W  exponent aligned to sum_in.
- out_valid  output  1  result valid. Held until accepted.
- out_ready  input  1  downstream accepts the result.
- sign_out  output  1  result sign.
- exp_out  output  EXP_W  normalized biased exponent.
- frac_out  output  MANT_W-1  fraction with the hidden bit removed.
- zero_out  output  1  result is exact zero.
- overflow_out  output  1  exponent saturated (infinity encoding).
- underflow_out  output  1  result flushed to zero because of exponent underflow.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All output registers clear to 0: out_valid, sign/exp/frac, and all flags.
  - in_ready reads 1 while in IDLE, including during reset.
  - Reset asserted in any state aborts the operation immediately; no partial result appears.
- States: IDLE, CHECK, SHIFT, DONE.
- IDLE:
  - On in_valid&in_ready at a clock edge, latch the operand:
    - sign = sum_in[MSB].
    - mag = sign ? (~sum_in+1) : sum_in, as MANT_W+2 bits unsigned.
    - exp_reg = exp_in.
  - Go to CHECK.
  - in_valid in any state other than IDLE is ignored.
- CHECK (one cycle), evaluated in priority order:
  1. mag==0: zero_out=1, sign=0, exp=0, frac=0, go to DONE.
  2. mag[MANT_W]=1: mag>>=1 (LSB truncated), exp_reg+1, go to DONE.
     - If exp_reg was all-ones: overflow_out=1, exp=all-ones, frac=0, sign kept.
  3. mag[MANT_W-1]=1: already normalized, go to DONE.
  4. Otherwise go to SHIFT.
- SHIFT, evaluated each cycle:
  - If exp_reg<=1: underflow_out=1, sign=0, exp=0, frac=0, go to DONE.
  - Else: mag<<=1, exp_reg-=1. If the new mag[MANT_W-1]=1, go to DONE.
- DONE:
  - out_valid=1.
  - Outputs and flags are stable while out_ready=0.
  - On out_valid&out_ready at a clock edge: out_valid=0, flags clear, go to IDLE.
- Latency: with k = number of leading zeros above the hidden-bit position, out_valid rises 1+k edges after the accept edge.
  - Zero, normalized and right-shift cases take 1 edge.
  - Maximum k is MANT_W-1.
- Throughput: one operation in flight. The next accept is possible no earlier than the cycle after the output handshake.
- Rounding: truncation only.
- Legal input range: sum_in = -2^(MANT_W+1) is outside the legal range and its result is unspecified.
- frac_out = mag[MANT_W-2:0] of the final mag.

Test Plan:
1. sum_in=0x0800000, exp_in=0x80 -> sign 0, exp 0x80, frac 0x000000. out_valid 1 edge after accept. No flags.
2. sum_in=0x3800000 (-2^23), exp_in=0x7F -> sign 1, exp 0x7F, frac 0. Then sum_in=0x1800000, exp_in=0x80 -> sign 0, exp 0x81, frac 0x400000.
3. sum_in=0x1000000, exp_in=0xFF -> overflow_out=1, exp 0xFF, frac 0, sign 0.
4. sum_in=0x0000001, exp_in=0x80 -> exp 0x69, frac 0, out_valid exactly 24 edges after accept. Then sum_in=0x0000100, exp_in=0x03 -> underflow_out=1, all fields 0.
5. sum_in=0, exp_in=0x55 -> zero_out=1, sign/exp/frac 0. Hold out_ready=0 for 5 cycles -> outputs unchanged and in_ready=0. Pulsing in_valid during that time has no effect.
6. Start sum_in=0x0000001 and assert rst during SHIFT -> out_valid=0 and in_ready=1 immediately without waiting for an edge. A new operand after release (case 1 values) completes correctly.
